// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and constants for the uart_tx arbiter.
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  localparam int CNT_W = 5;
  localparam int BUSY_TIMEOUT_DEF = 15;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake bus plus the uart_tx side of the arbiter.
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ-1:0] req_ready;
  logic [8*N_REQ-1:0] req_data;
  logic [7:0] uart_data;
  logic uart_start;
  logic uart_busy;
  modport master (output req_valid, req_data, req_last, uart_busy, input req_ready, uart_data, uart_start);
  modport slave (input req_valid, req_data, req_last, uart_busy, output req_ready, uart_data, uart_start);
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: round-robin pick starting at ptr; while locked only lock_idx is eligible.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             lock_en,
  input  logic [IDX_W-1:0] lock_idx,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    any = 1'b0;
    idx = '0;
    if (lock_en) begin
      any = req[lock_idx];
      idx = lock_idx;
    end else
      for (int i = N_REQ - 1; i >= 0; i--)
        if (req[(int'(ptr) + i) % N_REQ]) begin
          any = 1'b1;
          idx = IDX_W'((int'(ptr) + i) % N_REQ);
        end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among N_REQ byte producers.
// Define UART_ARB_FRAME_LOCK_EN to keep a multi-byte frame from one requester contiguous.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ),
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    bus,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_active,
  output logic                timeout_err
);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, gidx_n, pick, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0] data_q, data_n;
  logic [N_REQ-1:0] ready_q, ready_n;
  logic start_q, start_n, terr_n, lock, lock_n, lock_start, any;

  uart_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req(bus.req_valid), .ptr(ptr), .lock_en(lock), .lock_idx(grant_idx), .any(any), .idx(pick)
  );

`ifdef UART_ARB_FRAME_LOCK_EN
  assign lock_start = ~bus.req_last[pick];
`else
  assign lock_start = 1'b0;
`endif

  assign nxt = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_active = state != IDLE;
  assign bus.uart_data = data_q;
  assign bus.uart_start = start_q;
  assign bus.req_ready = ready_q;

  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    data_n = data_q;
    gidx_n = grant_idx;
    lock_n = lock;
    start_n = 1'b0;
    ready_n = '0;
    terr_n = 1'b0;
    case (state)
      IDLE: if (any) begin
        state_n = WAIT_BUSY;
        data_n = bus.req_data[8*pick +: 8];
        gidx_n = pick;
        start_n = 1'b1;
        ready_n[pick] = 1'b1;
        cnt_n = '0;
        lock_n = lock_start;
      end
      WAIT_BUSY: if (bus.uart_busy) state_n = WAIT_DONE;
      else if (cnt > CNT_W'(BUSY_TIMEOUT)) begin
        // byte was already acknowledged, so a timeout drops it and moves on
        state_n = IDLE;
        terr_n = 1'b1;
        lock_n = 1'b0;
        ptr_n = nxt;
      end else cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
      WAIT_DONE: if (!bus.uart_busy) begin
        state_n = IDLE;
        ptr_n = lock ? ptr : nxt;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      data_q <= '0;
      grant_idx <= '0;
      lock <= 1'b0;
      start_q <= 1'b0;
      ready_q <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      data_q <= data_n;
      grant_idx <= gidx_n;
      lock <= lock_n;
      start_q <= start_n;
      ready_q <= ready_n;
      timeout_err <= terr_n;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a small uart_tx busy model and a line log.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int FRAME = 5;
  localparam logic [7:0] EXP3_DATA [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  localparam int EXP3_IDX [5] = '{0, 1, 2, 3, 0};
  localparam int EXP3_RDY [4] = '{2, 1, 1, 1};
`ifdef UART_ARB_FRAME_LOCK_EN
  localparam logic [7:0] EXP6 [6] = '{8'hA0, 8'hB0, 8'hB1, 8'hB2, 8'hA1, 8'hA2};
`else
  localparam logic [7:0] EXP6 [6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
`endif
  localparam logic [7:0] D0 [3] = '{8'hA0, 8'hA1, 8'hA2};
  localparam logic [7:0] D1 [3] = '{8'hB0, 8'hB1, 8'hB2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] grant_idx;
  logic grant_active, timeout_err;
  int checks = 0, failures = 0;
  int busy_left = 0;
  bit starve = 1'b0;
  logic [7:0] line_q[$];
  int gidx_q[$];
  int rdy_cnt[N];

  uart_tx_arbiter_if #(.N_REQ(N)) bus();
  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .grant_idx(grant_idx), .grant_active(grant_active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for FRAME cycles after each start unless starved
  always @(negedge clk) begin
    if (bus.uart_start) begin
      line_q.push_back(bus.uart_data);
      gidx_q.push_back(int'(grant_idx));
    end
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) rdy_cnt[i]++;
    if (busy_left > 0) busy_left--;
    if (bus.uart_start && !starve) busy_left = FRAME;
    bus.uart_busy = busy_left > 0;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    busy_left = 0;
    bus.uart_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_start(string tag, int bound);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.uart_start && n < bound);
    chk(tag, bus.uart_start, 1);
  endtask

  task automatic wait_idle(string tag, int bound);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (grant_active && n < bound);
    chk(tag, grant_active, 0);
  endtask

  initial begin
    int n, k0, k1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.uart_busy = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_data", bus.uart_data, 0);
    chk("rst_start", bus.uart_start, 0);
    chk("rst_gidx", grant_idx, 0);
    chk("rst_active", grant_active, 0);
    chk("rst_terr", timeout_err, 0);
    @(negedge clk);
    reset = 1'b1;

    // single byte from requester 2
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'hA5;
    wait_start("t2_start", 4);
    chk("t2_ready", bus.req_ready, 4'b0100);
    chk("t2_data", bus.uart_data, 8'hA5);
    chk("t2_gidx", grant_idx, 2);
    chk("t2_active", grant_active, 1);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    chk("t2_start_drop", bus.uart_start, 0);
    chk("t2_ready_drop", bus.req_ready, 0);
    wait_idle("t2_idle", 30);
    chk("t2_data_hold", bus.uart_data, 8'hA5);
    chk("t2_gidx_hold", grant_idx, 2);

    // all requesters valid continuously
    do_reset();
    line_q.delete();
    gidx_q.delete();
    foreach (rdy_cnt[i]) rdy_cnt[i] = 0;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'hF;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (line_q.size() < 5 && n < 200);
    bus.req_valid = '0;
    chk("t3_count", line_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_byte%0d", i), i < line_q.size() ? 32'(line_q[i]) : 32'hDEAD, 32'(EXP3_DATA[i]));
      chk($sformatf("t3_idx%0d", i), i < gidx_q.size() ? gidx_q[i] : -1, EXP3_IDX[i]);
    end
    for (int i = 0; i < N; i++) chk($sformatf("t3_rdy%0d", i), rdy_cnt[i], EXP3_RDY[i]);
    wait_idle("t3_idle", 30);

    // starved uart: busy never rises
    do_reset();
    starve = 1'b1;
    bus.req_data[7:0] = 8'h21;
    bus.req_data[15:8] = 8'h22;
    bus.req_valid = 4'b0011;
    wait_start("t4_start", 4);
    chk("t4_gidx0", grant_idx, 0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!timeout_err && n < 40);
    chk("t4_latency", n, 17);
    chk("t4_idle", grant_active, 0);
    starve = 1'b0;
    @(negedge clk);
    #1;
    chk("t4_terr_pulse", timeout_err, 0);
    chk("t4_next_start", bus.uart_start, 1);
    chk("t4_next_gidx", grant_idx, 1);
    chk("t4_next_data", bus.uart_data, 8'h22);
    bus.req_valid = '0;
    wait_idle("t4_done", 30);

    // reset in the middle of a frame
    bus.req_data[15:8] = 8'h5C;
    bus.req_valid = 4'b0010;
    wait_start("t5_start", 4);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t5_active", grant_active, 1);
    bus.req_data[7:0] = 8'h3C;
    bus.req_data[31:24] = 8'h3F;
    bus.req_valid = 4'b1001;
    #2;
    reset = 1'b0;
    busy_left = 0;
    bus.uart_busy = 1'b0;
    #1;
    chk("t5_rst_start", bus.uart_start, 0);
    chk("t5_rst_ready", bus.req_ready, 0);
    chk("t5_rst_data", bus.uart_data, 0);
    chk("t5_rst_gidx", grant_idx, 0);
    chk("t5_rst_active", grant_active, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_start("t5_restart", 4);
    chk("t5_gidx", grant_idx, 0);
    chk("t5_data", bus.uart_data, 8'h3C);
    bus.req_valid = '0;
    wait_idle("t5_idle", 30);

    // requester 1 sends a 3-byte frame while requester 0 also streams
    do_reset();
    line_q.delete();
    k0 = 0;
    k1 = 0;
    n = 0;
    do begin
      bus.req_valid[0] = k0 < 3;
      bus.req_valid[1] = k1 < 3;
      bus.req_data[7:0] = k0 < 3 ? D0[k0] : 8'h00;
      bus.req_data[15:8] = k1 < 3 ? D1[k1] : 8'h00;
      bus.req_last[0] = 1'b1;
      bus.req_last[1] = k1 == 2;
      @(negedge clk);
      #1;
      n++;
      if (bus.req_ready[0]) k0++;
      if (bus.req_ready[1]) k1++;
    end while (line_q.size() < 6 && n < 300);
    bus.req_valid = '0;
    chk("t6_count", line_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t6_byte%0d", i), i < line_q.size() ? 32'(line_q[i]) : 32'hDEAD, 32'(EXP6[i]));
    wait_idle("t6_idle", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
